// File: rtl/kfmmc_request_arbiter_if.sv
// Requester-side and drive-side signals of the two-port KFMMC request arbiter.
// master = arbiter view, slave = requesters/drive view.
interface kfmmc_request_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [31:0] req_block_0;
    logic [31:0] req_block_1;
    logic [1:0]  grant;
    logic [7:0]  tx_byte_0;
    logic [7:0]  tx_byte_1;
    logic [1:0]  tx_valid;
    logic [1:0]  tx_ready;
    logic [7:0]  rx_byte;
    logic [1:0]  rx_valid;
    logic [1:0]  done;
    logic [1:0]  error;
    logic [7:0]  data_bus;
    logic        write_block_address_1;
    logic        write_block_address_2;
    logic        write_block_address_3;
    logic        write_block_address_4;
    logic        write_access_command;
    logic        write_data;
    logic        read_data;
    logic [7:0]  read_data_byte;
    logic        drive_busy;
    logic        read_byte_interrupt;
    logic        read_completion_interrupt;
    logic        request_write_data_interrupt;
    logic        write_completion_interrupt;
    logic        read_interface_error;
    logic        read_crc_error;
    logic        write_interface_error;

    modport master (
        input  req_valid, req_write, req_block_0, req_block_1, tx_byte_0, tx_byte_1, tx_valid,
               read_data_byte, drive_busy, read_byte_interrupt, read_completion_interrupt,
               request_write_data_interrupt, write_completion_interrupt,
               read_interface_error, read_crc_error, write_interface_error,
        output grant, tx_ready, rx_byte, rx_valid, done, error, data_bus,
               write_block_address_1, write_block_address_2, write_block_address_3,
               write_block_address_4, write_access_command, write_data, read_data
    );

    modport slave (
        output req_valid, req_write, req_block_0, req_block_1, tx_byte_0, tx_byte_1, tx_valid,
               read_data_byte, drive_busy, read_byte_interrupt, read_completion_interrupt,
               request_write_data_interrupt, write_completion_interrupt,
               read_interface_error, read_crc_error, write_interface_error,
        input  grant, tx_ready, rx_byte, rx_valid, done, error, data_bus,
               write_block_address_1, write_block_address_2, write_block_address_3,
               write_block_address_4, write_access_command, write_data, read_data
    );
endinterface

// File: rtl/kfmmc_request_arbiter.sv
// Round-robin share of one KFMMC drive between two requesters: address/command
// register sequencing, 512-byte block streaming, completion/error reporting.
module kfmmc_request_arbiter #(
    parameter logic [7:0]  READ_COMMAND  = 8'h80,
    parameter logic [7:0]  WRITE_COMMAND = 8'h81,
    parameter logic [9:0]  BLOCK_BYTES   = 10'd512,
    parameter logic [31:0] WATCHDOG      = 32'h00FFFFFF
) (
    input logic clock,
    input logic reset_n,
    kfmmc_request_arbiter_if.master bus
);
    typedef enum logic [3:0] {IDLE, A1, A2, A3, A4, CMD, RD, WR, FIN, DRAIN} state_t;

    state_t      state;
    logic        own, last_grant, is_write, pending, fin_pend, wd_flag;
    logic [31:0] block, wd_cnt;
    logic [9:0]  byte_cnt;
    logic [1:0]  grant_q, rx_valid_q, done_q, error_q;
    logic [7:0]  rx_byte_q, bus_q;
    logic [4:0]  strobe_q;

    logic        pick, start, accept, rd_strobe, drive_event, wd_hit, rd_fin, rd_err;
    logic [1:0]  own_mask;
    logic [7:0]  tx_own;
    logic [31:0] req_block;
    logic [9:0]  byte_cnt_inc;

    assign pick         = (&bus.req_valid) ? ~last_grant : bus.req_valid[1];
    assign start        = ~bus.drive_busy & (|bus.req_valid);
    assign req_block    = pick ? bus.req_block_1 : bus.req_block_0;
    assign own_mask     = own ? 2'b10 : 2'b01;
    assign tx_own       = own ? bus.tx_byte_1 : bus.tx_byte_0;
    // Read and write-data strobes answer the drive in the same cycle, so they are
    // decoded from state rather than registered.
    assign rd_strobe    = (state == RD) & bus.read_byte_interrupt;
    assign accept       = (state == WR) & pending & bus.tx_valid[own];
    assign drive_event  = bus.read_byte_interrupt | bus.read_completion_interrupt |
                          bus.request_write_data_interrupt | bus.write_completion_interrupt |
                          rd_strobe | accept;
    assign wd_hit       = ~drive_event & (wd_cnt == WATCHDOG - 32'd1);
    assign byte_cnt_inc = (byte_cnt == BLOCK_BYTES) ? byte_cnt : byte_cnt + 10'd1;
    // A completion arriving with a byte waits one cycle so the byte is forwarded first.
    assign rd_fin       = fin_pend | wd_hit | (bus.read_completion_interrupt & ~rd_strobe);
    assign rd_err       = bus.read_interface_error | bus.read_crc_error;

    assign bus.grant                 = grant_q;
    assign bus.rx_byte               = rx_byte_q;
    assign bus.rx_valid              = rx_valid_q;
    assign bus.done                  = done_q;
    assign bus.error                 = error_q;
    assign bus.write_block_address_1 = strobe_q[4];
    assign bus.write_block_address_2 = strobe_q[3];
    assign bus.write_block_address_3 = strobe_q[2];
    assign bus.write_block_address_4 = strobe_q[1];
    assign bus.write_access_command  = strobe_q[0];
    assign bus.write_data            = accept;
    assign bus.read_data             = rd_strobe;
    assign bus.tx_ready              = accept ? own_mask : 2'b00;
    assign bus.data_bus              = accept ? tx_own : bus_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            own        <= 1'b0;
            last_grant <= 1'b1;
            is_write   <= 1'b0;
            pending    <= 1'b0;
            fin_pend   <= 1'b0;
            wd_flag    <= 1'b0;
            block      <= '0;
            wd_cnt     <= '0;
            byte_cnt   <= '0;
            grant_q    <= '0;
            rx_valid_q <= '0;
            done_q     <= '0;
            error_q    <= '0;
            rx_byte_q  <= '0;
            bus_q      <= '0;
            strobe_q   <= '0;
        end else begin
            bus_q      <= '0;
            strobe_q   <= '0;
            rx_valid_q <= '0;
            done_q     <= '0;
            error_q    <= '0;
            case (state)
                IDLE: if (start) begin
                    own        <= pick;
                    last_grant <= pick;
                    grant_q    <= pick ? 2'b10 : 2'b01;
                    block      <= req_block;
                    is_write   <= bus.req_write[pick];
                    strobe_q   <= 5'b10000;
                    bus_q      <= req_block[7:0];
                    state      <= A1;
                end
                A1: begin strobe_q <= 5'b01000; bus_q <= block[15:8];  state <= A2; end
                A2: begin strobe_q <= 5'b00100; bus_q <= block[23:16]; state <= A3; end
                A3: begin strobe_q <= 5'b00010; bus_q <= block[31:24]; state <= A4; end
                A4: begin
                    strobe_q <= 5'b00001;
                    bus_q    <= is_write ? WRITE_COMMAND : READ_COMMAND;
                    state    <= CMD;
                end
                CMD: begin
                    byte_cnt <= '0;
                    wd_cnt   <= '0;
                    pending  <= 1'b0;
                    fin_pend <= 1'b0;
                    wd_flag  <= 1'b0;
                    state    <= is_write ? WR : RD;
                end
                RD: begin
                    wd_cnt <= drive_event ? 32'd0 : wd_cnt + 32'd1;
                    if (rd_strobe) begin
                        rx_byte_q <= bus.read_data_byte;
                        if (byte_cnt < BLOCK_BYTES) rx_valid_q <= own_mask;
                        byte_cnt <= byte_cnt_inc;
                    end
                    if (rd_fin) begin
                        done_q  <= own_mask;
                        error_q <= (rd_err | wd_hit | wd_flag) ? own_mask : 2'b00;
                        wd_flag <= wd_hit;
                        state   <= FIN;
                    end else if (bus.read_completion_interrupt) begin
                        fin_pend <= 1'b1;
                    end
                end
                WR: begin
                    wd_cnt  <= drive_event ? 32'd0 : wd_cnt + 32'd1;
                    pending <= (pending & ~accept) | (bus.request_write_data_interrupt & ~pending);
                    if (accept) byte_cnt <= byte_cnt_inc;
                    if (bus.write_completion_interrupt | wd_hit) begin
                        done_q  <= own_mask;
                        error_q <= (bus.write_interface_error | wd_hit | wd_flag) ? own_mask : 2'b00;
                        wd_flag <= wd_hit;
                        state   <= FIN;
                    end
                end
                FIN: begin
                    grant_q <= '0;
                    state   <= bus.drive_busy ? DRAIN : IDLE;
                end
                DRAIN: if (!bus.drive_busy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kfmmc_request_arbiter.sv
// Directed bench for kfmmc_request_arbiter: table of block transfers plus
// hand sequences for arbitration, watchdog, reset, busy and pending corner cases.
module tb_kfmmc_request_arbiter;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    kfmmc_request_arbiter_if bus();
    kfmmc_request_arbiter #(.WATCHDOG(32'd100)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    typedef struct {
        int          sel;
        logic        wr;
        logic [31:0] blk;
        int          nbytes;
        logic        crc, rdif, wrif;
        logic [7:0]  cmd;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return {bus.grant, bus.tx_ready, bus.rx_byte, bus.rx_valid, bus.done, bus.error,
                bus.data_bus, bus.write_block_address_1, bus.write_block_address_2,
                bus.write_block_address_3, bus.write_block_address_4,
                bus.write_access_command, bus.write_data, bus.read_data};
    endfunction

    function automatic logic [12:0] strobes();
        return {bus.write_block_address_1, bus.write_block_address_2, bus.write_block_address_3,
                bus.write_block_address_4, bus.write_access_command, bus.data_bus};
    endfunction

    task automatic addr_phase(input logic [1:0] exp_g, input logic [31:0] blk, input logic [7:0] cmd);
        int n = 0;
        do begin @(negedge clock); #1; n++; end while (bus.grant == 2'b00 && n < 20);
        check("grant", bus.grant, exp_g);
        check("addr1", strobes(), {5'b10000, blk[7:0]});
        @(negedge clock); #1; check("addr2", strobes(), {5'b01000, blk[15:8]});
        @(negedge clock); #1; check("addr3", strobes(), {5'b00100, blk[23:16]});
        @(negedge clock); #1; check("addr4", strobes(), {5'b00010, blk[31:24]});
        @(negedge clock); #1; check("cmd",   strobes(), {5'b00001, cmd});
    endtask

    task automatic read_bytes(input int n, input logic [1:0] mask, output int good, output int bad);
        good = 0; bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus.read_byte_interrupt = 1'b1;
            bus.read_data_byte = 8'(i);
            #1;
            if (bus.read_data !== 1'b1 || bus.data_bus !== 8'h00) bad++;
            @(negedge clock);
            bus.read_byte_interrupt = 1'b0;
            #1;
            if (bus.rx_valid === mask && bus.rx_byte === 8'(i)) good++;
        end
    endtask

    task automatic write_bytes(input int n, input int sel, output int good, output int bad);
        logic [1:0] mask;
        logic [7:0] b;
        mask = (sel == 1) ? 2'b10 : 2'b01;
        good = 0; bad = 0;
        bus.tx_valid = ~mask;
        for (int i = 0; i < n; i++) begin
            b = 8'(i * 7 + 3);
            @(negedge clock);
            bus.request_write_data_interrupt = 1'b1;
            #1;
            if (bus.write_data !== 1'b0) bad++;
            @(negedge clock);
            bus.request_write_data_interrupt = 1'b0;
            bus.tx_byte_0 = (sel == 0) ? b : ~b;
            bus.tx_byte_1 = (sel == 1) ? b : ~b;
            bus.tx_valid  = 2'b11;
            #1;
            if (bus.write_data === 1'b1 && bus.tx_ready === mask && bus.data_bus === b) good++;
            @(negedge clock);
            bus.tx_valid = ~mask;
            #1;
            if (bus.write_data !== 1'b0 || bus.tx_ready !== 2'b00) bad++;
        end
        bus.tx_valid = 2'b00;
    endtask

    task automatic finish_blk(input logic wr, input logic crc, input logic rdif, input logic wrif,
                              input logic [1:0] mask, input logic [1:0] exp_err);
        @(negedge clock);
        if (wr) bus.write_completion_interrupt = 1'b1;
        else    bus.read_completion_interrupt  = 1'b1;
        bus.read_crc_error        = crc;
        bus.read_interface_error  = rdif;
        bus.write_interface_error = wrif;
        #1;
        check("done_early", bus.done, 2'b00);
        @(negedge clock);
        bus.write_completion_interrupt = 1'b0;
        bus.read_completion_interrupt  = 1'b0;
        bus.read_crc_error        = 1'b0;
        bus.read_interface_error  = 1'b0;
        bus.write_interface_error = 1'b0;
        #1;
        check("done", bus.done, mask);
        check("error", bus.error, exp_err);
    endtask

    task automatic drop_req();
        @(negedge clock);
        bus.req_valid = 2'b00;
        #1;
        check("grant_release", bus.grant, 2'b00);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        int good, bad, n;
        logic [1:0] mask, seen;

        vt[0] = '{0, 1'b0, 32'h12345678, 512, 1'b0, 1'b0, 1'b0, 8'h80, 2'b00};
        vt[1] = '{1, 1'b1, 32'h00000000, 512, 1'b0, 1'b0, 1'b0, 8'h81, 2'b00};
        vt[2] = '{1, 1'b0, 32'hDEADBEEF,  20, 1'b1, 1'b0, 1'b1, 8'h80, 2'b10};
        vt[3] = '{0, 1'b0, 32'h0F1E2D3C,  10, 1'b0, 1'b1, 1'b0, 8'h80, 2'b01};
        vt[4] = '{0, 1'b1, 32'hCAFE0001,  12, 1'b0, 1'b0, 1'b1, 8'h81, 2'b01};
        vt[5] = '{1, 1'b1, 32'hA5C30F1E,   8, 1'b1, 1'b1, 1'b0, 8'h81, 2'b00};

        bus.req_valid = 0; bus.req_write = 0; bus.req_block_0 = 0; bus.req_block_1 = 0;
        bus.tx_byte_0 = 0; bus.tx_byte_1 = 0; bus.tx_valid = 0; bus.read_data_byte = 0;
        bus.drive_busy = 0; bus.read_byte_interrupt = 0; bus.read_completion_interrupt = 0;
        bus.request_write_data_interrupt = 0; bus.write_completion_interrupt = 0;
        bus.read_interface_error = 0; bus.read_crc_error = 0; bus.write_interface_error = 0;

        #12;
        check("reset_outputs", all_outputs(), 64'd0);
        @(negedge clock); reset_n = 1'b1;

        // Both requesters held for four blocks: grants alternate, 0 first.
        bus.req_block_0 = 32'h11223344; bus.req_block_1 = 32'h99AABBCC;
        @(negedge clock); bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            mask = (k % 2 == 0) ? 2'b01 : 2'b10;
            addr_phase(mask, (k % 2 == 0) ? 32'h11223344 : 32'h99AABBCC, 8'h80);
            finish_blk(1'b0, 1'b0, 1'b0, 1'b0, mask, 2'b00);
        end
        drop_req();

        for (int v = 0; v < 6; v++) begin
            mask = (vt[v].sel == 1) ? 2'b10 : 2'b01;
            @(negedge clock);
            bus.req_valid = mask;
            bus.req_write = vt[v].wr ? mask : 2'b00;
            bus.req_block_0 = (vt[v].sel == 0) ? vt[v].blk : ~vt[v].blk;
            bus.req_block_1 = (vt[v].sel == 1) ? vt[v].blk : ~vt[v].blk;
            addr_phase(mask, vt[v].blk, vt[v].cmd);
            if (vt[v].wr) write_bytes(vt[v].nbytes, vt[v].sel, good, bad);
            else          read_bytes(vt[v].nbytes, mask, good, bad);
            check("byte_count", good, vt[v].nbytes);
            check("strobe_errs", bad, 0);
            finish_blk(vt[v].wr, vt[v].crc, vt[v].rdif, vt[v].wrif, mask, vt[v].exp_err);
            drop_req();
        end

        // Watchdog: drive silent after the command.
        @(negedge clock); bus.req_valid = 2'b01; bus.req_write = 2'b00; bus.req_block_0 = 32'h0BADF00D;
        addr_phase(2'b01, 32'h0BADF00D, 8'h80);
        for (n = 0; n < 300; n++) begin
            @(negedge clock); #1;
            if (bus.done != 2'b00) break;
        end
        check("wd_cycles", n, 100);
        check("wd_done", bus.done, 2'b01);
        check("wd_error", bus.error, 2'b01);
        drop_req();

        // Bytes past the block size are strobed but not forwarded.
        @(negedge clock); bus.req_valid = 2'b10; bus.req_write = 2'b00; bus.req_block_1 = 32'h00000200;
        addr_phase(2'b10, 32'h00000200, 8'h80);
        read_bytes(512, 2'b10, good, bad);
        check("full_block", good, 512);
        @(negedge clock); bus.read_byte_interrupt = 1'b1; bus.read_data_byte = 8'h5A; #1;
        check("extra_strobe", bus.read_data, 1'b1);
        @(negedge clock); bus.read_byte_interrupt = 1'b0; #1;
        check("extra_not_fwd", bus.rx_valid, 2'b00);
        finish_blk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
        drop_req();

        // Completion together with a byte: byte forwarded, done the cycle after.
        @(negedge clock); bus.req_valid = 2'b01; bus.req_block_0 = 32'h76543210;
        addr_phase(2'b01, 32'h76543210, 8'h80);
        read_bytes(3, 2'b01, good, bad);
        @(negedge clock);
        bus.read_byte_interrupt = 1'b1; bus.read_completion_interrupt = 1'b1; bus.read_data_byte = 8'hEE;
        #1; check("sim_strobe", bus.read_data, 1'b1);
        @(negedge clock); bus.read_byte_interrupt = 1'b0; bus.read_completion_interrupt = 1'b0; #1;
        check("sim_fwd", {bus.rx_valid, bus.rx_byte, bus.done}, {2'b01, 8'hEE, 2'b00});
        @(negedge clock); #1;
        check("sim_done", {bus.done, bus.error}, {2'b01, 2'b00});
        drop_req();

        // Second write-data interrupt while pending is ignored.
        @(negedge clock); bus.req_valid = 2'b01; bus.req_write = 2'b01; bus.req_block_0 = 32'h00000042;
        addr_phase(2'b01, 32'h00000042, 8'h81);
        @(negedge clock); bus.request_write_data_interrupt = 1'b1; #1;
        @(negedge clock); #1;
        @(negedge clock); bus.request_write_data_interrupt = 1'b0; bus.tx_byte_0 = 8'hC3; bus.tx_valid = 2'b01; #1;
        check("pend_accept", {bus.write_data, bus.tx_ready, bus.data_bus}, {1'b1, 2'b01, 8'hC3});
        @(negedge clock); #1;
        check("pend_once", {bus.write_data, bus.tx_ready, bus.data_bus}, {1'b0, 2'b00, 8'h00});
        @(negedge clock); bus.tx_valid = 2'b00;
        finish_blk(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        bus.req_write = 2'b00;
        drop_req();

        // Reset in the middle of a read.
        @(negedge clock); bus.req_valid = 2'b10; bus.req_block_1 = 32'h13572468;
        addr_phase(2'b10, 32'h13572468, 8'h80);
        read_bytes(37, 2'b10, good, bad);
        check("pre_reset_bytes", good, 37);
        @(negedge clock); bus.read_byte_interrupt = 1'b1; reset_n = 1'b0; #1;
        check("midreset_outputs", all_outputs(), 64'd0);
        @(negedge clock); reset_n = 1'b1; bus.read_byte_interrupt = 1'b0; bus.req_valid = 2'b11;
        bus.req_block_0 = 32'h2468ACE0;
        addr_phase(2'b01, 32'h2468ACE0, 8'h80);
        finish_blk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        drop_req();

        // Busy drive blocks the grant.
        @(negedge clock); bus.drive_busy = 1'b1; bus.req_valid = 2'b10; bus.req_write = 2'b10;
        bus.req_block_1 = 32'h0000BEEF;
        seen = 2'b00;
        for (int i = 0; i < 8; i++) begin @(negedge clock); #1; seen |= bus.grant; end
        check("busy_no_grant", seen, 2'b00);
        @(negedge clock); bus.drive_busy = 1'b0;
        addr_phase(2'b10, 32'h0000BEEF, 8'h81);
        write_bytes(2, 1, good, bad);
        check("busy_wr_bytes", good, 2);
        finish_blk(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
        bus.req_write = 2'b00;
        drop_req();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/kfmmc_request_arbiter.md
Name: kfmmc_request_arbiter

Overview:
- Shares one KFMMC drive between two requesters, e.g. the disk-controller emulation and a boot loader.
- Arbitrates round-robin and sequences the drive's internal-bus register writes: block address bytes 1-4, then the access command.
- Streams 512 data bytes per block between the granted requester and the drive.
- Reports per-requester completion and error.

Parameters:
- READ_COMMAND, 8'h80, access-command code for a single-block read.
- WRITE_COMMAND, 8'h81, access-command code for a single-block write.
- BLOCK_BYTES, 10'd512, bytes transferred per block.
- WATCHDOG, 32'h00FFFFFF, clocks allowed without drive progress before abort.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  2  requester i wants one block; held until done[i]
- req_write  in  2  1 = write, 0 = read; stable while req_valid
- req_block_0  in  32  block address, requester 0
- req_block_1  in  32  block address, requester 1
- grant  out  2  one-hot owner of the drive
- tx_byte_0, tx_byte_1  in  8  write data from requester i
- tx_valid  in  2  tx_byte_i is valid
- tx_ready  out  2  byte accepted this cycle (pulse)
- rx_byte  out  8  read data to the owner
- rx_valid  out  2  rx_byte valid for requester i (pulse)
- done  out  2  block finished (pulse)
- error  out  2  with done: interface, CRC or watchdog error
- data_bus  out  8  drive internal bus
- write_block_address_1..4  out  1 each  address byte strobes; byte1 = bits 7:0, byte4 = bits 31:24
- write_access_command  out  1  command strobe
- write_data  out  1  write-data strobe
- read_data  out  1  read-data strobe
- read_data_byte  in  8  drive read byte, valid during the read_data cycle
- drive_busy  in  1  drive busy
- read_byte_interrupt, read_completion_interrupt, request_write_data_interrupt, write_completion_interrupt  in  1 each  drive events
- read_interface_error, read_crc_error, write_interface_error  in  1 each  drive error flags

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state IDLE, last_grant=1 so requester 0 wins first, counters 0.
- All strobes are single-cycle pulses; at most one strobe per cycle. data_bus is 0 except in strobe cycles.
- State IDLE:
  - Waits for drive_busy=0 and any req_valid.
  - Both valid: grant the index != last_grant.
  - Only one valid: grant it.
  - grant registered next cycle; last_grant updated; block and direction latched.
- States A1..A4: one state per cycle, pulsing write_block_address_n with the matching address byte.
- State CMD: pulses write_access_command with READ_COMMAND or WRITE_COMMAND. Byte counter cleared; watchdog cleared.
- State RD:
  - read_byte_interrupt -> pulse read_data the same cycle, capture read_data_byte.
  - Next cycle: rx_byte = captured byte, rx_valid[owner]=1, counter +1.
  - read_completion_interrupt -> FIN.
  - Read bytes beyond BLOCK_BYTES are strobed but not forwarded.
- State WR:
  - request_write_data_interrupt sets a pending flag.
  - While pending and tx_valid[owner]=1: pulse write_data with data_bus=tx_byte_owner, tx_ready[owner]=1, clear pending, counter +1.
  - write_completion_interrupt -> FIN.
  - A new interrupt while pending is already set is ignored.
- State FIN:
  - done[owner]=1 for one cycle.
  - error[owner] = read_interface_error|read_crc_error on reads, write_interface_error on writes, OR the watchdog flag.
  - Next cycle grant=0; return to IDLE only when drive_busy=0.
- Watchdog:
  - Counts in RD/WR; reset on any drive interrupt or strobe.
  - Reaching WATCHDOG -> latch watchdog flag, go to FIN.
- Byte counter is 10 bits and saturates at BLOCK_BYTES.
- Simultaneous completion and byte interrupt in RD: the byte is forwarded, then FIN.
- Requester deasserting req_valid mid-operation: the transfer still completes and done is pulsed; inputs from non-owners are ignored.
- tx_ready and rx_valid are only ever asserted for the owner.

Test Plan:
- Read: req_valid=01, req_write=0, block 32'h12345678 -> strobes on consecutive cycles with data_bus 78,56,34,12; write_access_command with 80. Drive 512 read_byte_interrupts with bytes 0..255 repeating -> 512 rx_valid[0] pulses with matching rx_byte; done=01, error=00.
- Write: requester 1, block 0 -> command 81. Each request_write_data_interrupt is answered with tx_valid one cycle later; write_data count=512; write_completion_interrupt -> done=10.
- Arbitration: both valid from reset -> grant 01 first, then 10. Hold both for 4 blocks -> grants alternate 01,10,01,10.
- Errors: read with read_crc_error=1 at completion -> done=01, error=01. Drive silent after CMD with WATCHDOG=100 -> done and error at cycle 100.
- Reset mid-transfer at byte 37: pull reset_n low -> all outputs 0 immediately. After release, a fresh request restarts the A1 sequence.
- drive_busy=1 held while req_valid -> no grant until drive_busy=0.
